// File: rtl/ax_btb_redirect_select_pkg.sv
// Shared fetch-unit types for the approximate-branch redirect selector:
// lane/PC sizing, redirect FSM states and the redirect request record.
package ax_btb_redirect_select_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int PC_WIDTH    = 32;
  localparam int AX_REDIRECT_COOLDOWN_CYCLES = 4;

  // $clog2 that never returns 0, so single-value fields still get one bit.
  function automatic int widthMin1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [PC_WIDTH-1:0] PC_Path;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    COOLDOWN
  } AxRedirectState;

  typedef struct packed {
    logic                                valid;
    PC_Path                              target;
    logic [widthMin1(FETCH_WIDTH)-1:0]   lane;
  } AxRedirectReq;

endpackage

// File: rtl/ax_btb_redirect_select_first_hit_encoder.sv
// Combinational priority encoder: oldest hitting lane, any-hit flag and the
// mask of lanes that survive (the hitting lane and everything older).
module ax_first_hit_encoder
  import ax_btb_redirect_select_pkg::*;
#(
  parameter int NUM_LANES = FETCH_WIDTH,
  parameter int LANE_W    = widthMin1(NUM_LANES)
) (
  input  logic                 fetchValid,
  input  logic [NUM_LANES-1:0] bufferHit,
  output logic [LANE_W-1:0]    hitLane,
  output logic                 anyHit,
  output logic [NUM_LANES-1:0] laneMask
);

  // hitBelow[k] is set when some lane older than k already hit.
  logic [NUM_LANES:0] hitBelow;

  assign hitBelow[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gLane
      assign hitBelow[gi+1] = hitBelow[gi] | bufferHit[gi];
      assign laneMask[gi]   = fetchValid & ~hitBelow[gi];
    end
  endgenerate

  assign anyHit = fetchValid & hitBelow[NUM_LANES];

  always_comb begin
    hitLane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (bufferHit[i]) hitLane = LANE_W'(i);
    end
  end

endmodule

// File: rtl/ax_btb_redirect_select.sv
// Fetch-stage redirect selector for approximate-branch buffer hits with stall
// hold and post-flush cooldown. Optional perf counters: AX_REDIRECT_PERF_EN.
module ax_btb_redirect_select #(
  parameter int FETCH_WIDTH     = ax_btb_redirect_select_pkg::FETCH_WIDTH,
  parameter int PC_WIDTH        = ax_btb_redirect_select_pkg::PC_WIDTH,
  parameter int COOLDOWN_CYCLES = ax_btb_redirect_select_pkg::AX_REDIRECT_COOLDOWN_CYCLES
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  fetchValid,
  input  logic [FETCH_WIDTH-1:0]                                bufferHit,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]                       bufferOut,
  input  logic                                                  stall,
  input  logic                                                  flush,
  output logic                                                  redirectValid,
  output logic [PC_WIDTH-1:0]                                   redirectTarget,
  output logic [ax_btb_redirect_select_pkg::widthMin1(FETCH_WIDTH)-1:0] redirectLane,
  output logic [FETCH_WIDTH-1:0]                                laneValidMask,
  output logic                                                  cooldownActive
`ifdef AX_REDIRECT_PERF_EN
  ,
  output logic [31:0]                                           perfRedirectCount,
  output logic [31:0]                                           perfSuppressedCount
`endif
);

  import ax_btb_redirect_select_pkg::*;

  localparam int LANE_W = widthMin1(FETCH_WIDTH);
  localparam int CNT_W  = widthMin1(COOLDOWN_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_RELOAD = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [FETCH_WIDTH-1:0] ALL_LANES  = '1;

  logic [LANE_W-1:0]      hitLane;
  logic                   anyHit;
  logic [FETCH_WIDTH-1:0] selMask;
  logic [PC_WIDTH-1:0]    laneTarget [FETCH_WIDTH];
  logic [PC_WIDTH-1:0]    selTarget;

  AxRedirectState         stateReg;
  logic [CNT_W-1:0]       cooldownCntReg;

  ax_first_hit_encoder #(
    .NUM_LANES (FETCH_WIDTH),
    .LANE_W    (LANE_W)
  ) uFirstHit (
    .fetchValid (fetchValid),
    .bufferHit  (bufferHit),
    .hitLane    (hitLane),
    .anyHit     (anyHit),
    .laneMask   (selMask)
  );

  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : gTarget
      assign laneTarget[gi] = bufferOut[gi*PC_WIDTH +: PC_WIDTH];
    end
  endgenerate

  // Targets pass through untouched; the encoder only chooses which lane.
  assign selTarget = laneTarget[hitLane];

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg       <= IDLE;
      cooldownCntReg <= '0;
      redirectValid  <= 1'b0;
      redirectTarget <= '0;
      redirectLane   <= '0;
      laneValidMask  <= '0;
      cooldownActive <= 1'b0;
    end else if (flush) begin
      // Any pending redirect is dropped; recovery PC owns NextPC now.
      redirectValid  <= 1'b0;
      laneValidMask  <= '0;
      if (COOLDOWN_CYCLES > 0) begin
        cooldownCntReg <= CNT_RELOAD;
        stateReg       <= COOLDOWN;
        cooldownActive <= 1'b1;
      end else begin
        stateReg       <= IDLE;
        cooldownActive <= 1'b0;
      end
    end else begin
      case (stateReg)
        COOLDOWN: begin
          // The window is measured in edges, so it drains even under stall.
          redirectValid <= 1'b0;
          if (cooldownCntReg != '0) cooldownCntReg <= cooldownCntReg - CNT_ONE;
          if (!stall) laneValidMask <= fetchValid ? ALL_LANES : '0;
          if (cooldownCntReg <= CNT_ONE) begin
            stateReg       <= IDLE;
            cooldownActive <= 1'b0;
          end
        end
        default: begin
          // IDLE and HOLD sample alike: an unstalled edge in HOLD consumes the
          // held redirect and captures the next group in the same cycle.
          if (!stall) begin
            redirectValid  <= anyHit;
            redirectTarget <= selTarget;
            redirectLane   <= hitLane;
            laneValidMask  <= selMask;
            stateReg       <= anyHit ? HOLD : IDLE;
          end
        end
      endcase
    end
  end

`ifdef AX_REDIRECT_PERF_EN
  logic sampleEdge;

  assign sampleEdge = !flush && !stall && anyHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      perfRedirectCount   <= '0;
      perfSuppressedCount <= '0;
    end else if (sampleEdge) begin
      if (stateReg == COOLDOWN) begin
        if (perfSuppressedCount != '1) perfSuppressedCount <= perfSuppressedCount + 32'd1;
      end else begin
        if (perfRedirectCount != '1) perfRedirectCount <= perfRedirectCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ax_btb_redirect_select.sv
// Bench for ax_btb_redirect_select: directed cycle table, then randomized
// traffic checked against a remaining-cooldown behavioural model.
module tb_ax_btb_redirect_select;

  localparam int COOL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchValid;
  logic [1:0]  bufferHit;
  logic [63:0] bufferOut;
  logic        stall;
  logic        flush;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [0:0]  redirectLane;
  logic [1:0]  laneValidMask;
  logic        cooldownActive;
`ifdef AX_REDIRECT_PERF_EN
  logic [31:0] perfRedirectCount;
  logic [31:0] perfSuppressedCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ax_btb_redirect_select #(
    .FETCH_WIDTH     (2),
    .PC_WIDTH        (32),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetchValid     (fetchValid),
    .bufferHit      (bufferHit),
    .bufferOut      (bufferOut),
    .stall          (stall),
    .flush          (flush),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .redirectLane   (redirectLane),
    .laneValidMask  (laneValidMask),
    .cooldownActive (cooldownActive)
`ifdef AX_REDIRECT_PERF_EN
    ,
    .perfRedirectCount   (perfRedirectCount),
    .perfSuppressedCount (perfSuppressedCount)
`endif
  );

  typedef struct {
    logic        rst;
    logic        fv;
    logic [1:0]  hit;
    logic [31:0] t0;
    logic [31:0] t1;
    logic        stall;
    logic        flush;
    logic        eValid;
    logic [31:0] eTgt;
    logic        eLane;
    logic [1:0]  eMask;
    logic        eCool;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic fv, logic [1:0] h, logic [31:0] a, logic [31:0] b,
                              logic s, logic f, logic ev, logic [31:0] et, logic el,
                              logic [1:0] em, logic ec);
    vec_t v;
    v.rst = r; v.fv = fv; v.hit = h; v.t0 = a; v.t1 = b; v.stall = s; v.flush = f;
    v.eValid = ev; v.eTgt = et; v.eLane = el; v.eMask = em; v.eCool = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fv, input logic [1:0] h, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic f);
    rst = r; fetchValid = fv; bufferHit = h; bufferOut = {b, a}; stall = s; flush = f;
  endtask

  // Behavioural model state: mCool counts remaining suppressed edges.
  int          mCool;
  logic        mValid;
  logic [31:0] mTgt;
  logic        mLane;
  logic [1:0]  mMask;

  task automatic modelStep(input logic r, input logic fv, input logic [1:0] h, input logic [31:0] a,
                           input logic [31:0] b, input logic s, input logic f);
    int first;
    if (r) begin
      mCool = 0; mValid = 0; mTgt = 0; mLane = 0; mMask = 0;
    end else if (f) begin
      mValid = 0; mMask = 0; mCool = COOL;
    end else if (mCool > 0) begin
      mCool--; mValid = 0;
      if (!s) mMask = fv ? 2'b11 : 2'b00;
    end else if (!s) begin
      first = -1;
      for (int i = 0; i < 2; i++) if (h[i] && first < 0) first = i;
      if (!fv) begin
        mValid = 0; mMask = 2'b00;
      end else if (first < 0) begin
        mValid = 0; mMask = 2'b11;
      end else begin
        mValid = 1;
        mLane  = (first == 1);
        mTgt   = (first == 0) ? a : b;
        for (int i = 0; i < 2; i++) mMask[i] = (i <= first);
      end
    end
  endtask

  initial begin
    drive(1, 0, 2'b00, 0, 0, 0, 0);

    vq.push_back(mk(1,0,2'b00,32'h0,32'h0,0,0,           0,32'h0,0,2'b00,0));
    vq.push_back(mk(0,1,2'b10,32'hAAAA,32'h1040,0,0,     1,32'h1040,1,2'b11,0));
    vq.push_back(mk(0,1,2'b11,32'h2000,32'h3000,0,0,     1,32'h2000,0,2'b01,0));
    vq.push_back(mk(0,0,2'b01,32'h4000,32'h0,0,0,        0,32'h0,0,2'b00,0));
    vq.push_back(mk(0,1,2'b01,32'h500,32'h510,0,0,       1,32'h500,0,2'b01,0));
    vq.push_back(mk(0,1,2'b10,32'h0,32'h999,1,0,         1,32'h500,0,2'b01,0));
    vq.push_back(mk(0,1,2'b11,32'h777,32'h778,1,0,       1,32'h500,0,2'b01,0));
    vq.push_back(mk(0,0,2'b00,32'h0,32'h0,1,0,           1,32'h500,0,2'b01,0));
    vq.push_back(mk(0,1,2'b10,32'h0,32'h1234,0,0,        1,32'h1234,1,2'b11,0));
    vq.push_back(mk(0,1,2'b01,32'h5555,32'h0,1,1,        0,32'h0,0,2'b00,1));
    vq.push_back(mk(0,1,2'b01,32'h6000,32'h0,0,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,0,2'b01,32'h6000,32'h0,1,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,0,2'b01,32'h6000,32'h0,0,0,        0,32'h0,0,2'b00,1));
    vq.push_back(mk(0,1,2'b10,32'h0,32'h6100,0,0,        0,32'h0,0,2'b11,0));
    vq.push_back(mk(0,1,2'b10,32'h0,32'h7000,0,0,        1,32'h7000,1,2'b11,0));
    vq.push_back(mk(0,1,2'b10,32'h0,32'h7100,0,1,        0,32'h0,0,2'b00,1));
    vq.push_back(mk(0,1,2'b01,32'h7200,32'h0,0,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,1,2'b01,32'h7200,32'h0,0,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(1,1,2'b01,32'h7300,32'h0,1,1,        0,32'h0,0,2'b00,0));
    vq.push_back(mk(0,1,2'b01,32'h8000,32'h0,0,0,        1,32'h8000,0,2'b01,0));
    vq.push_back(mk(0,0,2'b00,32'h0,32'h0,0,1,           0,32'h0,0,2'b00,1));
    vq.push_back(mk(0,1,2'b11,32'h8100,32'h8200,0,0,     0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,1,2'b11,32'h8100,32'h8200,0,1,     0,32'h0,0,2'b00,1));
    vq.push_back(mk(0,1,2'b01,32'h8300,32'h0,0,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,1,2'b01,32'h8300,32'h0,0,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,1,2'b01,32'h8300,32'h0,0,0,        0,32'h0,0,2'b11,1));
    vq.push_back(mk(0,1,2'b01,32'h8300,32'h0,0,0,        0,32'h0,0,2'b11,0));
    vq.push_back(mk(0,1,2'b01,32'h9000,32'h0,0,0,        1,32'h9000,0,2'b01,0));
    vq.push_back(mk(0,0,2'b00,32'h0,32'h0,0,0,           0,32'h0,0,2'b00,0));
    vq.push_back(mk(0,1,2'b01,32'hA000,32'h0,1,0,        0,32'h0,0,2'b00,0));
    vq.push_back(mk(0,1,2'b00,32'hB000,32'h0,0,0,        0,32'h0,0,2'b11,0));
    vq.push_back(mk(0,1,2'b11,32'hC000,32'hD000,0,0,     1,32'hC000,0,2'b01,0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].fv, vq[i].hit, vq[i].t0, vq[i].t1, vq[i].stall, vq[i].flush);
      @(posedge clk);
      #1;
      chk("valid", i, 32'(redirectValid), 32'(vq[i].eValid));
      chk("mask", i, 32'(laneValidMask), 32'(vq[i].eMask));
      chk("cooldown", i, 32'(cooldownActive), 32'(vq[i].eCool));
      if (vq[i].eValid || vq[i].rst) begin
        chk("target", i, redirectTarget, vq[i].eTgt);
        chk("lane", i, 32'(redirectLane), 32'(vq[i].eLane));
      end
      $display("vec %0d: valid=%0d tgt=%h lane=%0d mask=%b cool=%0d",
               i, redirectValid, redirectTarget, redirectLane, laneValidMask, cooldownActive);
    end

    // Randomized traffic; the first cycle is a reset to align the model.
    for (int n = 0; n < 2000; n++) begin
      logic        r, fv, s, f;
      logic [1:0]  h;
      logic [31:0] a, b;
      r  = (n == 0) || ($urandom_range(0, 99) == 0);
      fv = ($urandom_range(0, 9) < 8);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 29) == 0);
      h  = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      drive(r, fv, h, a, b, s, f);
      @(posedge clk);
      modelStep(r, fv, h, a, b, s, f);
      #1;
      chk("rnd_valid", n, 32'(redirectValid), 32'(mValid));
      chk("rnd_mask", n, 32'(laneValidMask), 32'(mMask));
      chk("rnd_cooldown", n, 32'(cooldownActive), 32'(mCool > 0));
      if (mValid) begin
        chk("rnd_target", n, redirectTarget, mTgt);
        chk("rnd_lane", n, 32'(redirectLane), 32'(mLane));
      end
      if (n % 100 == 0)
        $display("rnd %0d: valid=%0d tgt=%h mask=%b cool=%0d", n, redirectValid,
                 redirectTarget, laneValidMask, cooldownActive);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
